fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly downstream of the program counter. Takes the current PC,
//  issues the instruction-memory read, absorbs multi-cycle memory latency, and loads the IF/ID
//  pipeline register (instr, PC+4, valid). Honours decode-hazard stalls and control-hazard
//  flushes. Drives fetch_stall back to the PC so the PC holds while a fetch is outstanding.
// PARAMETERS
//  N   32  address/data width
//  CW  16  width of the saturating fetch-stall cycle counter
// PORTS
//  clock         in   1    rising-edge clock
//  reset         in   1    asynchronous, active-high reset
//  pc_in         in   N    current PC from the program counter
//  hold_in       in   1    decode hazard: freeze IF/ID contents this cycle
//  flush_in      in   1    control hazard: squash IF/ID and any pending fetch
//  imem_req      out  1    instruction-memory read request
//  imem_addr     out  N    read address; equals pc_in
//  imem_ready    in   1    imem_rdata valid this cycle (only sampled while imem_req=1)
//  imem_rdata    in   N    instruction word
//  fetch_stall   out  1    PC must hold (fetch outstanding or buffered word waiting)
//  fetch_err     out  1    one-cycle pulse: pc_in[1:0]!=0 at issue
//  if_id_instr   out  N    IF/ID instruction (0 = NOP when invalid)
//  if_id_pc4     out  N    IF/ID PC+4 of that instruction
//  if_id_valid   out  1    IF/ID holds a real instruction
//  stall_cycles  out  CW   count of cycles with fetch_stall=1, saturating
// BEHAVIOUR
//  Reset: state=ISSUE; if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_err=0, stall_cycles=0,
//   skid buffer empty. imem_req=0 while reset=1; first request in the first cycle after release.
//  States: ISSUE, HOLD. imem_req = (state==ISSUE) && !reset && pc_in[1:0]==0 && !flush_in.
//  ISSUE, imem_ready=1, hold_in=0: IF/ID <= {imem_rdata, pc_in+4 (mod 2^N), valid=1}; stay.
//  ISSUE, imem_ready=1, hold_in=1: IF/ID unchanged; word+PC+4 captured in skid buffer; ->HOLD.
//  ISSUE, imem_ready=0: fetch_stall=1; if hold_in=0, IF/ID <= bubble (instr=0, valid=0,
//   pc4 unchanged); if hold_in=1, IF/ID unchanged. Stay ISSUE; pc_in expected stable.
//  HOLD: imem_req=0, fetch_stall=1. When hold_in=0: IF/ID <= skid contents, valid=1; ->ISSUE.
//  flush_in=1 (any state, priority over hold_in and imem_ready): IF/ID <= bubble; skid cleared;
//   returned word discarded; ->ISSUE; fetch_stall=0 that cycle so PC loads its redirect target.
//  Misaligned pc_in in ISSUE (no flush): no request; fetch_err=1 for that cycle; IF/ID <= bubble
//   unless hold_in; fetch_stall=0. fetch_err registered-free combinational pulse, 0 otherwise.
//  fetch_stall = (ISSUE && imem_req && !imem_ready) || (HOLD && !flush_in).
//  Latency: zero-wait memory gives one instruction per cycle; IF/ID updates on the edge
//   ending the cycle imem_ready=1.
//  stall_cycles +1 each cycle fetch_stall=1; holds at 2^CW-1.
//  Async reset mid-fetch or in HOLD: immediate return to reset values; outstanding word dropped.
// TESTING
//  1 Reset, pc_in=0x0, imem_ready=1 rdata=0x20080005 -> next edge instr=0x20080005 pc4=0x4 valid=1.
//  2 imem_ready low 3 cycles at pc 0x8 -> fetch_stall=1 x3, bubbles valid=0, stall_cycles=3;
//    ready with 0x8C090000 -> instr=0x8C090000 pc4=0xC.
//  3 hold_in=1 while ready returns 0x012A5820 -> IF/ID unchanged, state HOLD, fetch_stall=1;
//    hold_in=0 -> instr=0x012A5820 valid=1, back to ISSUE, no re-request of same PC.
//  4 flush_in=1 in HOLD and again during outstanding fetch -> valid=0 instr=0, skid empty,
//    fetch_stall=0; next word fetched from new pc_in 0x40.
//  5 pc_in=0x6 -> imem_req=0, fetch_err=1 one cycle, valid=0.
//  6 Async reset asserted mid-wait (no clock edge) -> outputs 0 immediately; force 2^CW-1
//    stall cycles -> stall_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem reads for pc_in, absorbs memory wait
// states, parks a returned word in a one-entry skid buffer while decode is
// stalled, and loads the IF/ID pipeline register.
module fetch_stage #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  pc_in,
  input  logic          hold_in,
  input  logic          flush_in,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [N-1:0]  imem_rdata,
  output logic          fetch_stall,
  output logic          fetch_err,
  output logic [N-1:0]  if_id_instr,
  output logic [N-1:0]  if_id_pc4,
  output logic          if_id_valid,
  output logic [CW-1:0] stall_cycles
);

  typedef enum logic {
    ISSUE = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  skid_instr;
  logic [N-1:0]  skid_pc4;
  logic          skid_full;
  logic          pc_aligned;
  logic [N-1:0]  pc_plus4;

  assign pc_aligned = (pc_in[1:0] == 2'b00);
  assign pc_plus4   = pc_in + N'(4);
  assign imem_addr  = pc_in;

  // Request, stall-back-to-PC and misalignment pulse are all decoded from the current state and inputs
  always_comb begin
    imem_req    = 1'b0;
    fetch_err   = 1'b0;
    fetch_stall = 1'b0;
    if (!reset) begin
      if (state == ISSUE) begin
        imem_req    = pc_aligned && !flush_in;
        fetch_err   = !pc_aligned && !flush_in;
        fetch_stall = pc_aligned && !flush_in && !imem_ready;
      end else begin
        fetch_stall = !flush_in;
      end
    end
  end

  // Fetch FSM: flush wins, HOLD drains the skid buffer, ISSUE loads IF/ID or parks the word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ISSUE;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      skid_instr  <= '0;
      skid_pc4    <= '0;
      skid_full   <= 1'b0;
    end else if (flush_in) begin
      state       <= ISSUE;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
      skid_full   <= 1'b0;
    end else if (state == HOLD) begin
      if (!hold_in) begin
        if_id_instr <= skid_instr;
        if_id_pc4   <= skid_pc4;
        if_id_valid <= 1'b1;
        skid_full   <= 1'b0;
        state       <= ISSUE;
      end
    end else if (!pc_aligned) begin
      if (!hold_in) begin
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end
    end else if (imem_ready) begin
      if (!hold_in) begin
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end else begin
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_plus4;
        skid_full  <= 1'b1;
        state      <= HOLD;
      end
    end else if (!hold_in) begin
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end
  end

  // Saturating count of cycles in which the PC was told to hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (fetch_stall && (stall_cycles != {CW{1'b1}})) begin
      stall_cycles <= stall_cycles + CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: a vector table walks the main
// fetch, wait-state, hold, flush and misalignment behaviour, followed by
// hand-written sequences for async reset and counter saturation.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        hold_in;
  logic        flush_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        fetch_stall;
  logic        fetch_err;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] stall_cycles;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [31:0] pc;
    logic        hold;
    logic        flush;
    logic        ready;
    logic [31:0] rdata;
    logic        expReq;
    logic        expStall;
    logic        expErr;
    logic [31:0] expInstr;
    logic [31:0] expPc4;
    logic        expValid;
    logic [15:0] expCnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  fetch_stage #(.N(32), .CW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (pc_in),
    .hold_in      (hold_in),
    .flush_in     (flush_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .fetch_stall  (fetch_stall),
    .fetch_err    (fetch_err),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .stall_cycles (stall_cycles)
  );

  // Free-running 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a hung run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(
    input logic [31:0] pc, input logic hold, input logic flush, input logic ready,
    input logic [31:0] rdata, input logic req, input logic stall, input logic err,
    input logic [31:0] instr, input logic [31:0] pc4, input logic valid, input logic [15:0] cnt);
    vec_t v;
    v.pc = pc; v.hold = hold; v.flush = flush; v.ready = ready; v.rdata = rdata;
    v.expReq = req; v.expStall = stall; v.expErr = err;
    v.expInstr = instr; v.expPc4 = pc4; v.expValid = valid; v.expCnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive one vector just after a rising edge, check combinational outputs mid-cycle, registered outputs after the edge
  task automatic applyStimulus(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    tag = $sformatf("v%0d", idx);
    pc_in      = v.pc;
    hold_in    = v.hold;
    flush_in   = v.flush;
    imem_ready = v.ready;
    imem_rdata = v.rdata;
    @(negedge clock);
    checkOutput({tag, ".imem_req"},    32'(imem_req),    32'(v.expReq));
    checkOutput({tag, ".imem_addr"},   imem_addr,        v.pc);
    checkOutput({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(v.expStall));
    checkOutput({tag, ".fetch_err"},   32'(fetch_err),   32'(v.expErr));
    @(posedge clock);
    #1;
    checkOutput({tag, ".if_id_instr"}, if_id_instr,       v.expInstr);
    checkOutput({tag, ".if_id_pc4"},   if_id_pc4,         v.expPc4);
    checkOutput({tag, ".if_id_valid"}, 32'(if_id_valid),  32'(v.expValid));
    checkOutput({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(v.expCnt));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".imem_req"},     32'(imem_req),     32'd0);
    checkOutput({tag, ".fetch_stall"},  32'(fetch_stall),  32'd0);
    checkOutput({tag, ".fetch_err"},    32'(fetch_err),    32'd0);
    checkOutput({tag, ".if_id_instr"},  if_id_instr,       32'd0);
    checkOutput({tag, ".if_id_pc4"},    if_id_pc4,         32'd0);
    checkOutput({tag, ".if_id_valid"},  32'(if_id_valid),  32'd0);
    checkOutput({tag, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
  endtask

  initial begin
    //                 pc            hold flush rdy rdata         req stl err instr         pc4           vld cnt
    vecs[0]  = mkVec(32'h0000_0000, 0, 0, 1, 32'h2008_0005, 1, 0, 0, 32'h2008_0005, 32'h0000_0004, 1, 16'd0);
    vecs[1]  = mkVec(32'h0000_0004, 0, 0, 1, 32'h1111_1111, 1, 0, 0, 32'h1111_1111, 32'h0000_0008, 1, 16'd0);
    vecs[2]  = mkVec(32'h0000_0008, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 32'h0000_0008, 0, 16'd1);
    vecs[3]  = mkVec(32'h0000_0008, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 32'h0000_0008, 0, 16'd2);
    vecs[4]  = mkVec(32'h0000_0008, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 32'h0000_0008, 0, 16'd3);
    vecs[5]  = mkVec(32'h0000_0008, 0, 0, 1, 32'h8C09_0000, 1, 0, 0, 32'h8C09_0000, 32'h0000_000C, 1, 16'd3);
    vecs[6]  = mkVec(32'h0000_000C, 1, 0, 1, 32'h012A_5820, 1, 0, 0, 32'h8C09_0000, 32'h0000_000C, 1, 16'd3);
    vecs[7]  = mkVec(32'h0000_0010, 1, 0, 0, 32'h0000_0000, 0, 1, 0, 32'h8C09_0000, 32'h0000_000C, 1, 16'd4);
    vecs[8]  = mkVec(32'h0000_0010, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'h012A_5820, 32'h0000_0010, 1, 16'd5);
    vecs[9]  = mkVec(32'h0000_0010, 0, 0, 1, 32'h2222_2222, 1, 0, 0, 32'h2222_2222, 32'h0000_0014, 1, 16'd5);
    vecs[10] = mkVec(32'h0000_0014, 1, 0, 1, 32'h3333_3333, 1, 0, 0, 32'h2222_2222, 32'h0000_0014, 1, 16'd5);
    vecs[11] = mkVec(32'h0000_0018, 1, 1, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0014, 0, 16'd5);
    vecs[12] = mkVec(32'h0000_0040, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 32'h0000_0014, 0, 16'd6);
    vecs[13] = mkVec(32'h0000_0040, 0, 1, 1, 32'h4444_4444, 0, 0, 0, 32'h0000_0000, 32'h0000_0014, 0, 16'd6);
    vecs[14] = mkVec(32'h0000_0040, 0, 0, 1, 32'h5555_5555, 1, 0, 0, 32'h5555_5555, 32'h0000_0044, 1, 16'd6);
    vecs[15] = mkVec(32'h0000_0006, 0, 0, 1, 32'h6666_6666, 0, 0, 1, 32'h0000_0000, 32'h0000_0044, 0, 16'd6);
    vecs[16] = mkVec(32'h0000_0048, 0, 0, 1, 32'h7777_7777, 1, 0, 0, 32'h7777_7777, 32'h0000_004C, 1, 16'd6);
    vecs[17] = mkVec(32'h0000_0006, 1, 0, 1, 32'h6666_6666, 0, 0, 1, 32'h7777_7777, 32'h0000_004C, 1, 16'd6);
    vecs[18] = mkVec(32'h0000_004C, 1, 0, 0, 32'h0000_0000, 1, 1, 0, 32'h7777_7777, 32'h0000_004C, 1, 16'd7);
    vecs[19] = mkVec(32'h0000_004C, 0, 0, 1, 32'h8888_8888, 1, 0, 0, 32'h8888_8888, 32'h0000_0050, 1, 16'd7);
    vecs[20] = mkVec(32'hFFFF_FFFC, 0, 0, 1, 32'h9999_9999, 1, 0, 0, 32'h9999_9999, 32'h0000_0000, 1, 16'd7);

    reset      = 1'b1;
    pc_in      = 32'h0;
    hold_in    = 1'b0;
    flush_in   = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    #1;
    checkAllZero("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    checkAllZero("reset_edge");
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
    end

    // Async reset in the middle of a memory wait, away from any clock edge
    pc_in      = 32'h0000_0100;
    hold_in    = 1'b0;
    flush_in   = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("wait.fetch_stall", 32'(fetch_stall), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    imem_ready = 1'b1;
    imem_rdata = 32'hAAAA_AAAA;
    @(posedge clock);
    #1;
    checkOutput("reset_drop.if_id_valid", 32'(if_id_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset.imem_req", 32'(imem_req), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("post_reset.if_id_instr", if_id_instr, 32'hAAAA_AAAA);
    checkOutput("post_reset.if_id_pc4",   if_id_pc4,   32'h0000_0104);

    // Saturation of the stall counter after a clean reset
    reset = 1'b1;
    #1;
    checkOutput("sat_reset.stall_cycles", 32'(stall_cycles), 32'd0);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    pc_in      = 32'h0000_0200;
    imem_ready = 1'b0;
    repeat (65534) @(posedge clock);
    #1;
    checkOutput("sat.stall_cycles_fffe", 32'(stall_cycles), 32'h0000_FFFE);
    @(posedge clock);
    #1;
    checkOutput("sat.stall_cycles_ffff", 32'(stall_cycles), 32'h0000_FFFF);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("sat.stall_cycles_hold", 32'(stall_cycles), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
